gate_lab_seq: RTL and testbench
===============================

# gate_lab_seq

Parametrised, registered successor to the four-gate combinational demo tile. It provides up to four logic channels, each with a runtime-programmable 2-input operation, loaded through a synchronised serial config port. Outputs are registered, with per-channel rising-edge pulses. A free-running clock divider replaces the old clock-XOR toggle output. It sits as a Tiny Tapeout user tile behind the standard `tt_um` pin set.

## Interface
- `CHANNELS`, default 4: number of logic channels, legal range 1..4.
- `DIV_WIDTH`, default 8: width of the divider counter, minimum 2.

Ports:
- `clk`  in  1  single clock; all state is on its rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `ena`  in  1  high = operate; low = every register holds.
- `ui_in`  in  8  channel c operands: `a = ui_in[2c]`, `b = ui_in[2c+1]`.
- `uio_in`  in  8  bit0 = `cfg_data`, bit1 = `cfg_strobe`, bit2 = `cfg_commit`; bits 7:3 ignored.
- `uo_out`  out  8  bits[c] = `res[c]`; bits[4+c] = `rise[c]`; unused bits = 0.
- `uio_out`  out  8  bit7 = `div_clk`, bit6 = `cfg_pending`, bits 5:0 = 0.
- `uio_oe`  out  8  constant `8'hF0`.

## Operation
- Op codes (3 bits per channel):
  - 0 AND, 1 NAND, 2 OR, 3 NOR, 4 XOR, 5 XNOR, 6 NOT a, 7 BUF a.
- Registers:
  - `active[3*CHANNELS-1:0]`: ops currently applied.
  - `shadow[3*CHANNELS-1:0]`: ops being loaded.
  - `res`, `rise`: CHANNELS bits each.
  - `cfg_pending`.
  - `div_cnt`: DIV_WIDTH bits.
  - synchroniser and edge-detect flops for the config port.
- Reset values:
  - `active` and `shadow` per channel: ch0 = 1 (NAND), ch1 = 2 (OR), ch2 = 6 (NOT), ch3 = 4 (XOR), truncated to CHANNELS.
  - All other registers = 0.
  - Therefore every output is 0 during reset, except `uio_oe = 8'hF0`.
- Channel datapath, per enabled cycle:
  - `res[c] <= op(active[3c+2:3c], a, b)`.
  - `rise[c] <= ~res[c] & op(...)`, i.e. high in exactly the cycle where `res[c]` first shows 1.
- Config synchroniser:
  - `cfg_data`, `cfg_strobe` and `cfg_commit` each pass through a 2-flop synchroniser, then a 1-flop edge detector.
  - Only rising edges act.
- Shift event, on a `cfg_strobe` rise:
  - `shadow <= {data_sync, shadow[3*CHANNELS-1:1]}`.
  - `cfg_pending <= 1`.
  - After 3*CHANNELS shifts, the first bit sent sits in `shadow[0]` (ch0 op bit0). Bits are sent LSB-first per channel, channel 0 first.
- Commit event, on a `cfg_commit` rise:
  - `active <= shadow`.
  - `cfg_pending <= 0`.
- Shift and commit events in the same cycle:
  - `active` takes the pre-shift `shadow`.
  - `shadow` shifts.
  - `cfg_pending` = 1.
- Shift count is not checked. Extra shifts discard the oldest bits; fewer shifts leave partially-old contents. Commit is always honoured.
- Divider:
  - `div_cnt` increments by 1 each enabled cycle and wraps from all-ones to 0.
  - `div_clk = div_cnt[DIV_WIDTH-1]`; period 2^DIV_WIDTH enabled cycles, 50% duty.
- `ena` low: no register updates, including synchroniser flops; outputs hold.
- `rst_n` asserted mid-load: `shadow` and `active` return to the defaults; a partial load is lost.

## Timing
- Operand to `res`/`rise`: 1 cycle. `ui_in` is sampled on each rising edge and is treated as synchronous to `clk`.
- Raw config pin rise to action: the event takes effect on the 3rd rising edge after the pin is first sampled high.
- `cfg_data` must be stable from 3 cycles before the strobe rises until 3 cycles after.
- Minimum strobe high time and low time: 3 cycles each.
- Commit to new op: the op is visible in `res` on the edge after the commit edge.
- Reset: asynchronous assert. Deassertion is assumed synchronised upstream; the first update occurs on the first edge after release.

## Test plan
- Reset defaults:
  - Stimulus: reset, then `ui_in = 8'h03` with `ena = 1`.
  - Response: first cycle `uo_out = 8'h44`, next cycle `8'h04`.
  - Check: `uio_out = 8'h00` or `8'h80` per divider phase; `uio_oe = 8'hF0`.
- Full load:
  - Stimulus: shift 12 bits `1,0,1` ×4 (XNOR on all channels), then commit, with `ui_in = 8'h00`.
  - Response: `uio_out[6]` goes 1 after the first shift and returns to 0 after commit.
  - Response: `uo_out[3:0]` changes `4'b0100 → 4'b1111` one cycle after commit; `uo_out[7:4]` pulses `4'b1011` for one cycle.
- Shadow isolation:
  - Stimulus: shift 6 bits with no commit.
  - Response: `uo_out` is unchanged for 50 cycles; `cfg_pending = 1`.
- Simultaneous shift and commit:
  - Stimulus: raise `cfg_strobe` and `cfg_commit` on the same cycle.
  - Response: `active` equals the pre-shift shadow; `cfg_pending = 1`.
- `ena` freeze and divider:
  - Stimulus: `DIV_WIDTH = 2`; hold `ena = 0` for 10 cycles mid-run.
  - Response: `div_clk` pattern is 0,0,1,1, and it and all outputs freeze while `ena = 0`.
- Reset mid-load:
  - Stimulus: assert `rst_n` after 5 shifts.
  - Response: outputs go to 0 immediately (asynchronous); after release, default ops apply.

Source files
------------

// File: rtl/gate_lab_seq.sv
// gate_lab_seq: registered programmable logic channels behind a Tiny Tapeout pin set.
// Ops load serially into a shadow register and are committed atomically.
module gate_lab_seq #(
  parameter int CHANNELS  = 4,
  parameter int DIV_WIDTH = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] ui_in,
  input  logic [7:0] uio_in,
  output logic [7:0] uo_out,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);

  localparam int OW = 3 * CHANNELS;
  localparam logic [11:0] DEF_ALL = 12'b100_110_010_001;
  localparam logic [OW-1:0] DEF = DEF_ALL[OW-1:0];
  localparam logic [DIV_WIDTH-1:0] ONE = 1;

  logic [OW-1:0]        active;
  logic [OW-1:0]        shadow;
  logic [CHANNELS-1:0]  res;
  logic [CHANNELS-1:0]  rise;
  logic [CHANNELS-1:0]  nxt;
  logic                 pending;
  logic [DIV_WIDTH-1:0] div_cnt;
  logic [2:0]           sync1;
  logic [2:0]           sync2;
  logic [2:0]           sync_prev;
  logic                 shift_ev;
  logic                 commit_ev;

  function automatic logic op_eval(
    input logic [2:0] op,
    input logic       a,
    input logic       b
  );
    logic r;
    unique case (op)
      3'd0:    r = a & b;
      3'd1:    r = ~(a & b);
      3'd2:    r = a | b;
      3'd3:    r = ~(a | b);
      3'd4:    r = a ^ b;
      3'd5:    r = ~(a ^ b);
      3'd6:    r = ~a;
      default: r = a;
    endcase
    return r;
  endfunction

  always_comb begin
    nxt = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      nxt[c] = op_eval(active[3*c +: 3],
                       ui_in[2*c], ui_in[2*c+1]);
    end
  end

  assign shift_ev  = sync2[1] & ~sync_prev[1];
  assign commit_ev = sync2[2] & ~sync_prev[2];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      active    <= DEF;
      shadow    <= DEF;
      res       <= '0;
      rise      <= '0;
      pending   <= 1'b0;
      div_cnt   <= '0;
      sync1     <= '0;
      sync2     <= '0;
      sync_prev <= '0;
    end else if (ena) begin
      sync1     <= uio_in[2:0];
      sync2     <= sync1;
      sync_prev <= sync2;
      res       <= nxt;
      rise      <= ~res & nxt;
      div_cnt   <= div_cnt + ONE;
      // commit reads shadow before any same-cycle shift lands
      if (commit_ev) active <= shadow;
      if (shift_ev) begin
        shadow  <= {sync2[0], shadow[OW-1:1]};
        pending <= 1'b1;
      end else if (commit_ev) begin
        pending <= 1'b0;
      end
    end
  end

  always_comb begin
    uo_out = '0;
    uo_out[CHANNELS-1:0]  = res;
    uo_out[4 +: CHANNELS] = rise;
  end

  assign uio_out = {div_cnt[DIV_WIDTH-1], pending, 6'b0};
  assign uio_oe  = 8'hF0;

  logic unused_pins;
  assign unused_pins = &{1'b0, uio_in[7:3], ui_in};

endmodule

// File: tb/tb_gate_lab_seq.sv
// Scoreboard bench for gate_lab_seq: a behavioural model predicts outputs,
// a monitor compares them one cycle later.
module tb_gate_lab_seq;

  localparam int CH = 4;
  localparam int DW = 2;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ena = 1'b0;
  logic [7:0] ui_in = '0;
  logic [7:0] uio_in = '0;
  logic [7:0] uo_out;
  logic [7:0] uio_out;
  logic [7:0] uio_oe;

  gate_lab_seq #(.CHANNELS(CH), .DIV_WIDTH(DW)) dut (
    .clk(clk), .rst_n(rst_n), .ena(ena),
    .ui_in(ui_in), .uio_in(uio_in),
    .uo_out(uo_out), .uio_out(uio_out), .uio_oe(uio_oe)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] uo;
    logic [7:0] uio;
  } exp_t;

  exp_t exp_q[$];
  int   n_chk = 0;
  int   n_pass = 0;

  int   act[4];
  bit   sh[$];
  bit   mres[4];
  bit   mrise[4];
  bit   mpend;
  int   mcnt;
  bit [2:0] h1, h2, h3;

  logic [7:0] ui_fix;
  bit         ui_rand;

  task automatic check(input string nm, input logic [7:0] got,
                       input logic [7:0] want);
    n_chk++;
    if (got === want) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", nm, got, want, $time);
  endtask

  function automatic bit ref_op(input int op, input bit a, input bit b);
    case (op)
      0: return a && b;
      1: return !(a && b);
      2: return a || b;
      3: return !(a || b);
      4: return a != b;
      5: return a == b;
      6: return !a;
      default: return a;
    endcase
  endfunction

  task automatic model_reset();
    act = '{1, 2, 6, 4};
    sh.delete();
    for (int c = 0; c < CH; c++)
      for (int k = 0; k < 3; k++) sh.push_back(bit'((act[c] >> k) & 1));
    for (int c = 0; c < 4; c++) begin
      mres[c] = 0;
      mrise[c] = 0;
    end
    mpend = 0;
    mcnt = 0;
    h1 = 0; h2 = 0; h3 = 0;
  endtask

  task automatic model_step();
    bit sev, cev, d, n;
    exp_t e;
    if (!rst_n) begin
      model_reset();
    end else if (ena) begin
      sev = h2[1] && !h3[1];
      cev = h2[2] && !h3[2];
      d = h2[0];
      for (int c = 0; c < CH; c++) begin
        n = ref_op(act[c], ui_in[2*c], ui_in[2*c+1]);
        mrise[c] = !mres[c] && n;
        mres[c] = n;
      end
      if (cev)
        for (int c = 0; c < CH; c++)
          act[c] = sh[3*c] + 2 * sh[3*c+1] + 4 * sh[3*c+2];
      if (sev) begin
        void'(sh.pop_front());
        sh.push_back(d);
      end
      if (sev) mpend = 1;
      else if (cev) mpend = 0;
      mcnt = (mcnt + 1) % (1 << DW);
      h3 = h2; h2 = h1; h1 = uio_in[2:0];
    end
    e.uo = '0;
    for (int c = 0; c < CH; c++) begin
      e.uo[c] = mres[c];
      e.uo[4+c] = mrise[c];
    end
    e.uio = {mcnt >= (1 << (DW - 1)), mpend, 6'b0};
    exp_q.push_back(e);
  endtask

  task automatic drive(input logic [2:0] cfg, input bit en, input bit r);
    @(negedge clk);
    ui_in = ui_rand ? 8'($urandom) : ui_fix;
    uio_in = {5'($urandom), cfg};
    ena = en;
    if (!r && rst_n) begin
      rst_n = 1'b0;
      #1;
      check("rst_uo", uo_out, 8'h00);
      check("rst_uio", uio_out, 8'h00);
      check("rst_oe", uio_oe, 8'hF0);
    end
    rst_n = r;
    model_step();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(3'b000, 1'b1, 1'b1);
  endtask

  task automatic send_bit(input bit d);
    for (int i = 0; i < 3; i++) drive({2'b00, d}, 1'b1, 1'b1);
    for (int i = 0; i < 3; i++) drive({2'b01, d}, 1'b1, 1'b1);
    for (int i = 0; i < 3; i++) drive({2'b00, d}, 1'b1, 1'b1);
  endtask

  task automatic send_both(input bit d);
    for (int i = 0; i < 3; i++) drive({2'b00, d}, 1'b1, 1'b1);
    for (int i = 0; i < 3; i++) drive({2'b11, d}, 1'b1, 1'b1);
    for (int i = 0; i < 3; i++) drive({2'b00, d}, 1'b1, 1'b1);
  endtask

  task automatic commit();
    for (int i = 0; i < 3; i++) drive(3'b100, 1'b1, 1'b1);
    for (int i = 0; i < 3; i++) drive(3'b000, 1'b1, 1'b1);
  endtask

  always @(posedge clk) begin
    exp_t e;
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("uo_out", uo_out, e.uo);
      check("uio_out", uio_out, e.uio);
      check("uio_oe", uio_oe, 8'hF0);
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: bench did not finish, got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [2:0] cfg;
    int hold;
    model_reset();
    ui_rand = 0;
    ui_fix = 8'h03;
    for (int i = 0; i < 3; i++) drive(3'b000, 1'b0, 1'b0);

    // defaults: first 8'h44 then 8'h04
    idle(6);

    // full load of XNOR on every channel
    ui_fix = 8'h00;
    for (int i = 0; i < 12; i++) send_bit(bit'(i % 3 != 1));
    commit();
    idle(4);

    // shadow isolation
    ui_fix = 8'($urandom);
    for (int i = 0; i < 6; i++) send_bit(bit'($urandom));
    idle(50);

    // simultaneous shift and commit, then commit the shifted shadow
    send_both(bit'($urandom));
    idle(5);
    commit();
    idle(3);

    // ena freeze with pins wiggling
    ui_rand = 1;
    idle(5);
    for (int i = 0; i < 10; i++) drive(3'($urandom), 1'b0, 1'b1);
    idle(8);

    // reset mid-load
    for (int i = 0; i < 5; i++) send_bit(bit'($urandom));
    for (int i = 0; i < 3; i++) drive(3'b000, 1'b1, 1'b0);
    ui_rand = 0;
    ui_fix = 8'h03;
    idle(6);

    // random traffic
    ui_rand = 1;
    hold = 0;
    cfg = 3'b000;
    for (int i = 0; i < 400; i++) begin
      if (hold == 0) begin
        cfg = 3'($urandom);
        hold = $urandom_range(1, 6);
      end
      hold--;
      drive(cfg, $urandom_range(0, 9) != 0, 1'b1);
    end

    repeat (2) @(negedge clk);
    n_chk++;
    if (exp_q.size() == 0) n_pass++;
    else $display("FAIL drain: got %0d pending expected 0", exp_q.size());

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
